// File: rtl/sfu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sfu_pkg
// Brief    : Shared types and default geometry for the SFU psum streamer.
// Revision : 1.0 - initial release
// ============================================================================
package sfu_pkg;

    localparam int C_COL     = 8;
    localparam int C_PSUM_BW = 16;
    localparam int C_NUM_KIJ = 9;
    localparam int C_NUM_OUT = 16;
    localparam int C_ADDR_W  = 8;

    localparam int ROW_W     = C_PSUM_BW * C_COL;
    localparam int BEATS_ACC = C_NUM_OUT * (C_NUM_KIJ + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sfu_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : sfu_skid_buf
// Brief    : Output register plus one-entry skid register (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module sfu_skid_buf #(
    parameter int W = 131
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_full,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_out_v;
    logic         r_skid_v;
    logic [W-1:0] r_out_d;
    logic [W-1:0] r_skid_d;
    logic         w_load;

    assign w_load  = !r_out_v || i_ready;
    assign o_full  = r_skid_v;
    assign o_valid = r_out_v;
    assign o_data  = r_out_d;

    // Upstream never presents data while the skid is full and the output holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out_d  <= '0;
            r_skid_d <= '0;
        end else if (w_load) begin
            if (r_skid_v) begin
                r_out_v  <= 1'b1;
                r_out_d  <= r_skid_d;
                r_skid_v <= i_valid;
                if (i_valid) r_skid_d <= i_data;
            end else begin
                r_out_v <= i_valid;
                if (i_valid) r_out_d <= i_data;
            end
        end else if (i_valid) begin
            r_skid_v <= 1'b1;
            r_skid_d <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sfu_psum_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sfu_psum_streamer
// Brief    : Streams psum rows from SRAM into the SFU with kij accumulation.
// Revision : 1.0 - initial release
// ============================================================================
module sfu_psum_streamer
    import sfu_pkg::*;
#(
    parameter int COL     = C_COL,
    parameter int PSUM_BW = C_PSUM_BW,
    parameter int NUM_KIJ = C_NUM_KIJ,
    parameter int NUM_OUT = C_NUM_OUT,
    parameter int ADDR_W  = C_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_i,
    input  logic                     cfg_bypass_i,
    input  logic                     cfg_mp_i,
    output logic                     mem_cen_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    input  logic [PSUM_BW*COL-1:0]   mem_rdata_i,
    output logic [PSUM_BW*COL-1:0]   psum_out,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     acc_o,
    output logic                     psum_bypass_o,
    output logic                     max_pool_en_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int                C_ROW_W   = PSUM_BW * COL;
    localparam int                C_KW      = $clog2(NUM_KIJ + 1);
    localparam logic [ADDR_W-1:0] C_STRIDE  = ADDR_W'(NUM_OUT);
    localparam logic [ADDR_W-1:0] C_LAST_O  = ADDR_W'(NUM_OUT - 1);
    localparam logic [C_KW-1:0]   C_DRAIN_K = C_KW'(NUM_KIJ);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_byp;
    logic                r_mp;
    logic [C_KW-1:0]     r_k;
    logic [ADDR_W-1:0]   r_o;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_pend;
    logic                r_pend_drain;
    logic                w_skid_full;
    logic                w_out_hold;
    logic                w_can_issue;
    logic                w_is_drain;
    logic                w_last_slot;
    logic                w_flush_done;
    logic [C_ROW_W-1:0]  w_row;
    logic [2:0]          w_ctrl;
    logic [C_ROW_W+2:0]  w_in_data;
    logic [C_ROW_W+2:0]  w_out_data;

    // A drain beat occupies an issue slot without touching the SRAM, which
    // keeps it ordered behind the last kij read of its output position.
    assign w_out_hold   = out_valid_o && !out_ready_i;
    assign w_can_issue  = (r_state == S_RUN) && !w_skid_full && !(w_out_hold && r_pend);
    assign w_is_drain   = !r_byp && (r_k == C_DRAIN_K);
    assign w_last_slot  = (r_o == C_LAST_O) && (r_byp || w_is_drain);
    assign w_flush_done = !r_pend && !w_skid_full && out_valid_o && out_ready_i;

    assign mem_cen_o  = !(w_can_issue && !w_is_drain);
    assign mem_addr_o = r_addr;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);

    assign w_row     = r_pend_drain ? '0 : mem_rdata_i;
    assign w_ctrl    = r_pend_drain ? {2'b00, r_mp} : (r_byp ? {2'b01, r_mp} : 3'b100);
    assign w_in_data = {w_row, w_ctrl};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = S_RUN;
            S_RUN:   if (w_can_issue && w_last_slot) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_flush_done) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Running base: +NUM_OUT per kij, reloaded with the next output index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byp        <= 1'b0;
            r_mp         <= 1'b0;
            r_k          <= '0;
            r_o          <= '0;
            r_addr       <= '0;
            r_pend       <= 1'b0;
            r_pend_drain <= 1'b0;
        end else begin
            r_pend       <= w_can_issue;
            r_pend_drain <= w_can_issue && w_is_drain;
            if (r_state == S_IDLE && start_i) begin
                r_byp  <= cfg_bypass_i;
                r_mp   <= cfg_mp_i;
                r_k    <= '0;
                r_o    <= '0;
                r_addr <= '0;
            end else if (r_state == S_DONE) begin
                r_addr <= '0;
            end else if (w_can_issue) begin
                if (r_byp) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_o    <= r_o + ADDR_W'(1);
                end else if (w_is_drain) begin
                    r_k    <= '0;
                    r_o    <= r_o + ADDR_W'(1);
                    r_addr <= r_o + ADDR_W'(1);
                end else begin
                    r_k    <= r_k + C_KW'(1);
                    r_addr <= r_addr + C_STRIDE;
                end
            end
        end
    end

    sfu_skid_buf #(
        .W (C_ROW_W + 3)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .i_valid (r_pend),
        .i_data  (w_in_data),
        .o_full  (w_skid_full),
        .o_valid (out_valid_o),
        .o_data  (w_out_data),
        .i_ready (out_ready_i)
    );

    assign psum_out      = w_out_data[C_ROW_W+2:3];
    assign acc_o         = w_out_data[2];
    assign psum_bypass_o = w_out_data[1];
    assign max_pool_en_o = w_out_data[0];

endmodule
`default_nettype wire

// File: tb/tb_sfu_psum_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sfu_psum_streamer
// Brief    : Scoreboard bench for sfu_psum_streamer with an SRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sfu_psum_streamer;
    import sfu_pkg::*;

    localparam int C_W  = ROW_W + 3;
    localparam int C_OV = ROW_W + C_ADDR_W + 7;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start_i = 1'b0;
    logic                cfg_bypass_i = 1'b0;
    logic                cfg_mp_i = 1'b0;
    logic                out_ready_i = 1'b1;
    logic                mem_cen_o;
    logic [C_ADDR_W-1:0] mem_addr_o;
    logic [ROW_W-1:0]    mem_rdata_i;
    logic [ROW_W-1:0]    psum_out;
    logic                out_valid_o, acc_o, psum_bypass_o, max_pool_en_o, busy_o, done_o;

    int                  checks = 0;
    int                  errors = 0;
    int                  beat_cnt = 0;
    int                  done_cnt = 0;
    logic [C_W-1:0]      exp_q[$];
    logic                exp_done = 1'b0;
    logic                prev_hold = 1'b0;
    logic [C_W:0]        prev_snap;
    logic [C_OV-1:0]     rst_exp;

    always #5 clk = ~clk;

    sfu_psum_streamer dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .cfg_bypass_i  (cfg_bypass_i),
        .cfg_mp_i      (cfg_mp_i),
        .mem_cen_o     (mem_cen_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .psum_out      (psum_out),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .acc_o         (acc_o),
        .psum_bypass_o (psum_bypass_o),
        .max_pool_en_o (max_pool_en_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    function automatic logic [ROW_W-1:0] row_of(input int a);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < C_COL; i++) r[i*C_PSUM_BW +: C_PSUM_BW] = a[C_PSUM_BW-1:0];
        return r;
    endfunction

    function automatic logic [C_OV-1:0] out_vec();
        return {mem_cen_o, mem_addr_o, psum_out, out_valid_o, acc_o, psum_bypass_o,
                max_pool_en_o, busy_o, done_o};
    endfunction

    function automatic logic rdy_pat(input int c);
        logic [3:0] pat;
        pat = 4'b1001;
        if ((c % 29) >= 24) return 1'b0;
        return pat[c % 4];
    endfunction

    // SRAM model: word at address a is {COL{a}}, one cycle read latency
    always @(posedge clk) begin
        if (!mem_cen_o) mem_rdata_i <= row_of(int'(mem_addr_o));
    end

    // Output monitor: scoreboard pops, stall stability, done timing, read gating
    always @(negedge clk) begin
        logic [C_W-1:0] got;
        logic [C_W-1:0] e_beat;
        if (!reset) begin
            prev_hold = 1'b0;
            exp_done  = 1'b0;
        end else begin
            got = {psum_out, acc_o, psum_bypass_o, max_pool_en_o};
            if (done_o) begin
                checks++;
                if (!exp_done) begin
                    errors++;
                    $display("FAIL done_unexpected: done_o=1 required 0 at %0t", $time);
                end else begin
                    done_cnt++;
                end
                exp_done = 1'b0;
            end else if (exp_done) begin
                checks++;
                errors++;
                $display("FAIL done_timing: done_o=0 required 1 at %0t", $time);
                exp_done = 1'b0;
            end
            if (prev_hold) begin
                checks++;
                if ({out_valid_o, got} !== prev_snap) begin
                    errors++;
                    $display("FAIL stall_hold: got %h required %h", {out_valid_o, got}, prev_snap);
                end
            end
            if (!mem_cen_o) begin
                checks++;
                if (dut.w_skid_full !== 1'b0) begin
                    errors++;
                    $display("FAIL read_while_skid_full: skid_full=%b required 0", dut.w_skid_full);
                end
            end
            if (out_valid_o && out_ready_i) begin
                checks++;
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %h required none", got);
                end else begin
                    e_beat = exp_q.pop_front();
                    if (got !== e_beat) begin
                        errors++;
                        $display("FAIL beat_%0d: got %h required %h", beat_cnt - 1, got, e_beat);
                    end
                    if (exp_q.size() == 0) exp_done = 1'b1;
                end
            end
            prev_hold = out_valid_o && !out_ready_i;
            prev_snap = {out_valid_o, got};
        end
    end

    task automatic launch(input logic byp, input logic mp);
        if (byp) begin
            for (int o = 0; o < C_NUM_OUT; o++) exp_q.push_back({row_of(o), 2'b01, mp});
        end else begin
            for (int o = 0; o < C_NUM_OUT; o++) begin
                for (int k = 0; k < C_NUM_KIJ; k++)
                    exp_q.push_back({row_of(k * C_NUM_OUT + o), 3'b100});
                exp_q.push_back({ROW_W'(0), 2'b00, mp});
            end
        end
        beat_cnt = 0;
        @(posedge clk); #1;
        cfg_bypass_i = byp;
        cfg_mp_i     = mp;
        start_i      = 1'b1;
        @(posedge clk); #1;
        start_i      = 1'b0;
        cfg_bypass_i = 1'b0;
        cfg_mp_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int mode, input int beats);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            out_ready_i = (mode == 0) ? 1'b1 : rdy_pat(c);
            if (done_cnt != d0) seen = 1'b1;
        end
        out_ready_i = 1'b1;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL job_timeout: no done_o within %0d cycles", budget);
        end
        checks++;
        if (beat_cnt != beats || exp_q.size() != 0) begin
            errors++;
            $display("FAIL beat_count: got %0d (pending %0d) required %0d", beat_cnt, exp_q.size(), beats);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_vec() !== rst_exp) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", out_vec(), rst_exp);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_latency();
        launch(1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (mem_cen_o !== 1'b0 || mem_addr_o !== '0) begin
            errors++;
            $display("FAIL latency_read_c1: cen=%b addr=%0d required cen=0 addr=0", mem_cen_o, mem_addr_o);
        end
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_valid_c2: got %b required 0", out_valid_o);
        end
        @(negedge clk);
        checks++;
        if (out_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL latency_valid_c3: got %b required 1", out_valid_o);
        end
        wait_done(2000, 0, BEATS_ACC);
    endtask

    task automatic test_reset_midrun();
        launch(1'b0, 1'b1);
        for (int c = 0; c < 2000 && beat_cnt < 37; c++) @(posedge clk);
        checks++;
        if (beat_cnt < 37) begin
            errors++;
            $display("FAIL midrun_reach: got %0d beats required 37", beat_cnt);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (out_vec() !== rst_exp) begin
            errors++;
            $display("FAIL abort_outputs: got %h required %h", out_vec(), rst_exp);
        end
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || mem_cen_o !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_abort: busy=%b valid=%b cen=%b required 0 0 1",
                     busy_o, out_valid_o, mem_cen_o);
        end
    endtask

    task automatic test_accumulate();
        launch(1'b0, 1'b1);
        wait_done(2000, 0, BEATS_ACC);
    endtask

    task automatic test_bypass();
        launch(1'b1, 1'b1);
        wait_done(500, 0, C_NUM_OUT);
    endtask

    task automatic test_backpressure();
        launch(1'b0, 1'b1);
        wait_done(5000, 1, BEATS_ACC);
    endtask

    task automatic test_start_ignored();
        launch(1'b0, 1'b0);
        for (int p = 0; p < 2; p++) begin
            repeat (40) @(posedge clk);
            #1;
            checks++;
            if (busy_o !== 1'b1) begin
                errors++;
                $display("FAIL busy_during_run: got %b required 1", busy_o);
            end
            cfg_bypass_i = 1'b1;
            cfg_mp_i     = 1'b1;
            start_i      = 1'b1;
            @(posedge clk); #1;
            start_i      = 1'b0;
            cfg_bypass_i = 1'b0;
            cfg_mp_i     = 1'b0;
        end
        wait_done(2000, 0, BEATS_ACC);
    endtask

    initial begin
        rst_exp = '0;
        rst_exp[C_OV-1] = 1'b1;
        test_reset();
        test_latency();
        test_reset_midrun();
        test_accumulate();
        test_bypass();
        test_backpressure();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
